// File: rtl/sram_controller.sv
// 32-bit MEM-stage responder over a 16-bit async SRAM, two half-word accesses.
// Optional: SRAM_RANGE_CHECK_EN completes out-of-window requests without access.
module sram_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] w_q, w_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic        we_n_q, we_n_d;
  logic        oe_q, oe_d;
  logic [15:0] dq_q, dq_d;
  logic        req;
  logic        in_range;
  logic        active;

  assign req = wr_en | rd_en;

`ifdef SRAM_RANGE_CHECK_EN
  logic [32:0] a33;
  assign a33      = {1'b0, address};
  assign in_range = (a33 >= 33'(BASE)) &&
                    (a33 < 33'(BASE) + 33'h8_0000);
`else
  assign in_range = 1'b1;
`endif

  // Outputs are computed from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    w_d     = w_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr_en;
          w_d     = 17'((address - BASE) >> 2);
          wdata_d = write_data;
          cnt_d   = 4'd0;
          if (in_range) begin
            state_d = LO;
          end else begin
            state_d = DONE;
            if (!wr_en) rdata_d = '0;
          end
        end
      end
      LO: begin
        if (cnt_q == LAST) begin
          state_d = HI;
          cnt_d   = 4'd0;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    active = (state_d == LO) || (state_d == HI);
    addr_d = active ? {w_d, state_d == HI} : '0;
    oe_d   = active & wr_d;
    we_n_d = ~(oe_d & (cnt_d < LAST));
    dq_d   = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      w_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      w_q     <= w_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
    end
  end

  assign SRAM_DQ   = oe_q ? dq_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = rdata_q;
  assign ready     = ((state_q == IDLE) & ~req) | (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small async SRAM model.
// The model commits a half-word on the WE_N rising edge unless reset aborts it.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  wire         we_n, ce_n, oe_n, ub_n, lb_n;

  logic        tb_rd = 1'b0;
  logic        tb_probe = 1'b0;
  logic [15:0] mem [64];
  logic [5:0]  la;
  logic [15:0] ld;

  int checks = 0;
  int failures = 0;
  int lows, wes;
  logic [17:0] a0, a1;
  logic [15:0] d0, d1;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (we_n),
    .SRAM_CE_N  (ce_n),
    .SRAM_OE_N  (oe_n),
    .SRAM_UB_N  (ub_n),
    .SRAM_LB_N  (lb_n)
  );

  assign SRAM_DQ = tb_rd    ? mem[SRAM_ADDR[5:0]] :
                   tb_probe ? 16'hA5C3 : 16'hzzzz;

  always @(negedge clk) begin
    if (!we_n) begin
      la <= SRAM_ADDR[5:0];
      ld <= SRAM_DQ;
    end
  end

  always @(posedge we_n) begin
    if (!rst) mem[la] <= ld;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    tb_rd = rd & ~wr;
    lows = 0;
    wes = 0;
    a0 = '1;
    a1 = '1;
    d0 = '1;
    d1 = '1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lows++;
      if (!we_n) wes++;
      if (lows == 2) begin
        a0 = SRAM_ADDR;
        d0 = SRAM_DQ;
      end
      if (lows == 5) begin
        a1 = SRAM_ADDR;
        d1 = SRAM_DQ;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    tb_rd = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tb_probe = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_dq_free", {16'd0, SRAM_DQ}, 32'h0000_A5C3);
    tb_probe = 1'b0;

    run(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("wr_lows", lows, 32'd7);
    chk("wr_wes", wes, 32'd4);
    chk("wr_a0", {14'd0, a0}, 32'd0);
    chk("wr_a1", {14'd0, a1}, 32'd1);
    chk("wr_d0", {16'd0, d0}, 32'h0000_BEEF);
    chk("wr_d1", {16'd0, d1}, 32'h0000_DEAD);
    chk("wr_done_we_n", {31'd0, we_n}, 32'd1);
    chk("wr_rdata", read_data, 32'd0);
    idle();

    run(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("rd_lows", lows, 32'd7);
    chk("rd_wes", wes, 32'd0);
    chk("rd_a0", {14'd0, a0}, 32'd0);
    chk("rd_a1", {14'd0, a1}, 32'd1);
    chk("rd_data", read_data, 32'hDEADBEEF);
    idle();

    run(1'b1, 1'b1, 32'd1032, 32'h12345678);
    chk("both_lows", lows, 32'd7);
    chk("both_wes", wes, 32'd4);
    chk("both_a0", {14'd0, a0}, 32'd4);
    chk("both_a1", {14'd0, a1}, 32'd5);
    chk("both_d0", {16'd0, d0}, 32'h0000_5678);
    chk("both_d1", {16'd0, d1}, 32'h0000_1234);
    chk("both_rdata", read_data, 32'hDEADBEEF);
    idle();

    run(1'b0, 1'b1, 32'd1032, 32'd0);
    chk("rd1032", read_data, 32'h12345678);
    idle();

    run(1'b1, 1'b0, 32'd1028, 32'h11112222);
    chk("pre1028_lows", lows, 32'd7);
    idle();
    run(1'b1, 1'b0, 32'd1036, 32'h33334444);
    chk("pre1036_lows", lows, 32'd7);
    idle();

    @(posedge clk);
    #1;
    wr_en = 1'b1;
    address = 32'd1024;
    write_data = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_hi_addr", {14'd0, SRAM_ADDR}, 32'd1);
    chk("abort_hi_we_n", {31'd0, we_n}, 32'd0);
    rst = 1'b1;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_probe = 1'b1;
    @(negedge clk);
    chk("abort_we_n", {31'd0, we_n}, 32'd1);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_rdata", read_data, 32'd0);
    chk("abort_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("abort_dq_free", {16'd0, SRAM_DQ}, 32'h0000_A5C3);
    tb_probe = 1'b0;

    run(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("partial_rd", read_data, 32'hDEADF00D);
    idle();

    run(1'b0, 1'b1, 32'd1028, 32'd0);
    chk("b2b1_lows", lows, 32'd7);
    chk("b2b1_a0", {14'd0, a0}, 32'd2);
    chk("b2b1_a1", {14'd0, a1}, 32'd3);
    chk("b2b1_data", read_data, 32'h11112222);
    run(1'b0, 1'b1, 32'd1036, 32'd0);
    chk("b2b2_lows", lows, 32'd7);
    chk("b2b2_a0", {14'd0, a0}, 32'd6);
    chk("b2b2_a1", {14'd0, a1}, 32'd7);
    chk("b2b2_data", read_data, 32'h33334444);
    idle();

`ifdef SRAM_RANGE_CHECK_EN
    run(1'b0, 1'b1, 32'd16, 32'd0);
    chk("oor_lows", lows, 32'd1);
    chk("oor_wes", wes, 32'd0);
    chk("oor_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("oor_rdata", read_data, 32'd0);
    idle();
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the MEM stage of the ARM pipeline. It replaces the single-cycle data memory with an external 16-bit asynchronous SRAM. It accepts one 32-bit read or write request at a time and performs it as two 16-bit SRAM accesses with a fixed number of wait cycles each. While it is busy it deasserts `ready`, and the pipeline's freeze logic holds all stage registers until `ready` returns high.

## Interface
- `WAIT_CYCLES`, default 3: SRAM cycles per 16-bit half-access. Legal range is 2..15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset. Synchronous and active-high.
- `wr_en` input, 1 bit: MEM-stage write request. Level, held until `ready`.
- `rd_en` input, 1 bit: MEM-stage read request. Level, held until `ready`.
- `address` input, 32 bits: byte address (ALU result).
- `write_data` input, 32 bits: store data (Rm value).
- `read_data` output, 32 bits: load data.
- `ready` output, 1 bit: high when no request is outstanding or the current request completes this cycle.
- `SRAM_ADDR` output, 18 bits: SRAM half-word address.
- `SRAM_DQ` inout, 16 bits: SRAM data bus.
- `SRAM_WE_N`, `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` outputs, 1 bit each: SRAM strobes, active-low.

## Operation
- States:
  - IDLE: no access in progress.
  - LO: access to the low half-word, bits 15:0.
  - HI: access to the high half-word, bits 31:16.
  - DONE: completion, one cycle.
- A 4-bit phase counter `cnt` runs from 0 to WAIT_CYCLES-1 inside LO and HI.
- Request is `wr_en | rd_en`. If both are high, the request is a write.
- Transitions:
  - IDLE to LO when a request is present. Latch the request type. Set `cnt`=0.
  - LO to HI when `cnt`==WAIT_CYCLES-1. Set `cnt`=0.
  - HI to DONE when `cnt`==WAIT_CYCLES-1.
  - DONE to IDLE unconditionally.
- Address mapping: `w = (address - BASE_ADDR) >> 2`, truncated to 17 bits. In LO, `SRAM_ADDR = {w,1'b0}`. In HI, `SRAM_ADDR = {w,1'b1}`. In IDLE and DONE, `SRAM_ADDR` is 0.
- `address` bits 1:0 are ignored. There are no byte writes.
- Strobes:
  - `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N` and `SRAM_LB_N` are tied 0.
  - `SRAM_WE_N` is 0 only for a write in LO or HI with `cnt` < WAIT_CYCLES-1. The last cycle of each phase is a hold cycle with WE_N high.
- Data bus:
  - For a write, `SRAM_DQ` is driven with `write_data[15:0]` in LO and `write_data[31:16]` in HI, for the whole phase.
  - In every other case `SRAM_DQ` is high-Z.
- Read capture:
  - On the last LO cycle, `read_data[15:0] <= SRAM_DQ`.
  - On the last HI cycle, `read_data[31:16] <= SRAM_DQ`.
  - `read_data` holds its value until the next read overwrites it. Writes do not change it.
- `ready` is combinational: `(state==IDLE & ~(wr_en|rd_en)) | state==DONE`.
- The request inputs are sampled only in IDLE. Changes to them during LO or HI are ignored.

## Timing
- Reset values: state IDLE, `cnt` 0, `read_data` 0, `SRAM_WE_N` 1, `SRAM_DQ` high-Z, `SRAM_ADDR` 0.
- `ready` is 1 after reset while no request is present.
- Latency:
  - A request arriving in IDLE sees `ready`=0 for 1+2·WAIT_CYCLES cycles, then `ready`=1 for exactly one cycle (DONE).
  - The default is 7 cycles low and ready in the 8th cycle.
- The pipeline advances on the clock edge that ends the DONE cycle. A request present in the following IDLE cycle is treated as new.
- Back-to-back requests: the next access begins one cycle after DONE, so there is no dead cycle beyond the IDLE cycle.
- Reset mid-access: aborts immediately at the next edge. WE_N goes high and DQ is released in that cycle. A partial write of the low half may remain in the SRAM. `read_data` is cleared.

## Configuration
- `SRAM_RANGE_CHECK_EN` defined:
  - A request with `address < BASE_ADDR` or `address >= BASE_ADDR + 2^19` goes from IDLE straight to DONE.
  - `ready` is low for 1 cycle.
  - No strobes are asserted.
  - A read returns `read_data` = 0.
- `SRAM_RANGE_CHECK_EN` undefined: every address is accessed with the truncated mapping above.

## Test plan
- Reset, then idle: `ready`=1, `SRAM_WE_N`=1, DQ high-Z, `read_data`=0.
- Write 0xDEADBEEF to address 1024, then read address 1024:
  - The write drives SRAM address 0 with 0xBEEF, then address 1 with 0xDEAD.
  - WE_N is low for 2 cycles per phase.
  - The read returns 0xDEADBEEF in the DONE cycle.
  - `ready` is low 7 cycles each time.
- `wr_en`=`rd_en`=1 at address 1032 with data 0x12345678: a write occurs to SRAM addresses 4 and 5, and `read_data` is unchanged.
- `rst` pulsed in the second HI cycle of a write: state returns to IDLE and WE_N=1 on the next cycle. A subsequent read of the same address returns the new low half and the old high half.
- Two back-to-back reads of 1028 and 1036 with the inputs changed on the DONE edge: both complete, each with 7 low cycles. `SRAM_ADDR` sequences 2,3 then 6,7.
- With `SRAM_RANGE_CHECK_EN`, a read of address 16: `ready` is low for exactly 1 cycle, no WE_N or DQ activity, and `read_data`=0.
